// File: rtl/uart_rx_if.sv
// Register-port bundle for the UART receiver: Wishbone-style strobe/acknowledge
// bus between a host (master) and the receiver (slave).
interface uart_rx_if;
  logic [1:0] wb_addr;
  logic [7:0] wb_data_in;
  logic [7:0] wb_data_out;
  logic       wb_we;
  logic       wb_stb;
  logic       wb_ack;

  modport master (
    output wb_addr, wb_data_in, wb_we, wb_stb,
    input  wb_data_out, wb_ack
  );

  modport slave (
    input  wb_addr, wb_data_in, wb_we, wb_stb,
    output wb_data_out, wb_ack
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a 4-entry receive FIFO, framing/overrun flags and a
// small register port (DATA at 0, STATUS at 1).
module uart_rx #(
  parameter int CLK_FREQ     = 12000000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_bit,
  uart_rx_if.slave   bus,
  output logic       rx_irq,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             push_q, push_d;
  logic [7:0]       push_data_q, push_data_d;
  logic [7:0]       mem_q [4];
  logic [7:0]       mem_d [4];
  logic [1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]       count_q, count_d;
  logic             overrun_q, overrun_d, frame_err_q, frame_err_d;
  logic             ack_q, ack_d;
  logic [7:0]       data_out_q, data_out_d;
  logic             irq_q, irq_d;

  logic       fall, frame_set, access, pop, clr_ovr, clr_fe, full, do_push, ovr_set;
  logic [7:0] status;
  logic       unused_data_bits;

  assign unused_data_bits = ^{bus.wb_data_in[7:4], bus.wb_data_in[1:0]};

  assign fall   = prev_q & ~sync2_q;
  assign full   = (count_q == 3'd4);
  assign status = {1'b0, count_q, frame_err_q, overrun_q, full, (count_q != 3'd0)};

  always_comb begin
    sync1_d     = rx_bit;
    sync2_d     = sync1_q;
    prev_d      = sync2_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    frame_set   = 1'b0;

    // Each state counts down to zero, then samples the synchronised line once.
    case (state_q)
      S_IDLE: begin
        if (fall) begin
          state_d = S_START;
          cnt_d   = HALF_M1;
        end
      end
      S_START: begin
        if (cnt_q == '0) begin
          if (!sync2_q) begin
            state_d   = S_DATA;
            cnt_d     = FULL_M1;
            bit_idx_d = 3'd0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          shift_d   = {sync2_q, shift_q[7:1]};
          cnt_d     = FULL_M1;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_STOP: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          if (sync2_q) begin
            push_d      = 1'b1;
            push_data_d = shift_q;
          end else begin
            frame_set = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus handshake: an access executes on any cycle with wb_stb=1 and wb_ack=0;
  // wb_ack is then high for exactly the next cycle, with read data held
  // in wb_data_out until the next read.
  always_comb begin
    access     = bus.wb_stb & ~ack_q;
    ack_d      = access;
    data_out_d = data_out_q;
    pop        = 1'b0;
    clr_ovr    = 1'b0;
    clr_fe     = 1'b0;
    if (access) begin
      if (!bus.wb_we) begin
        case (bus.wb_addr)
          2'd0: begin
            if (count_q != 3'd0) begin
              data_out_d = mem_q[rd_ptr_q];
              pop        = 1'b1;
            end else begin
              data_out_d = 8'h00;
            end
          end
          2'd1:    data_out_d = status;
          default: data_out_d = 8'h00;
        endcase
      end else if (bus.wb_addr == 2'd1) begin
        clr_ovr = bus.wb_data_in[2];
        clr_fe  = bus.wb_data_in[3];
      end
    end
  end

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  always_comb begin
    do_push  = push_q & (~full | pop);
    ovr_set  = push_q & full & ~pop;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data_q;
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 2'd1;
    case ({do_push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    if (clr_ovr)   overrun_d   = 1'b0;
    if (ovr_set)   overrun_d   = 1'b1;
    if (clr_fe)    frame_err_d = 1'b0;
    if (frame_set) frame_err_d = 1'b1;
    irq_d = (count_q != 3'd0);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      push_q      <= 1'b0;
      push_data_q <= 8'h00;
      wr_ptr_q    <= 2'd0;
      rd_ptr_q    <= 2'd0;
      count_q     <= 3'd0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      ack_q       <= 1'b0;
      data_out_q  <= 8'h00;
      irq_q       <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      ack_q       <= ack_d;
      data_out_q  <= data_out_d;
      irq_q       <= irq_d;
    end
  end

  // Storage needs no reset: pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.wb_ack      = ack_q;
  assign bus.wb_data_out = data_out_q;
  assign rx_irq          = irq_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: serial frames driven bit by bit, results read
// back over the register port and compared with hand-computed values.
module tb_uart_rx;
  localparam int CPB = 104;

  logic       clk;
  logic       reset_n;
  logic       rx_bit;
  logic       rx_irq;
  logic [1:0] dbg_state;

  uart_rx_if bus ();

  uart_rx #(.CLK_FREQ(12000000), .BAUD(115200)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx_bit    (rx_bit),
    .bus       (bus),
    .rx_irq    (rx_irq),
    .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
    end
  endtask

  // driver tasks: every task starts and ends 1 time unit after a rising edge
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_val);
    rx_bit = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_bit = b[i];
      wait_cycles(CPB);
    end
    rx_bit = stop_val;
    wait_cycles(CPB);
    rx_bit = 1'b1;
  endtask

  task automatic bus_access(input logic we, input logic [1:0] a, input logic [7:0] wd,
                            output logic [7:0] rd);
    logic got_ack;
    got_ack        = 1'b0;
    bus.wb_addr    = a;
    bus.wb_we      = we;
    bus.wb_data_in = wd;
    bus.wb_stb     = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (bus.wb_ack) begin
        got_ack = 1'b1;
        break;
      end
    end
    rd         = bus.wb_data_out;
    bus.wb_stb = 1'b0;
    bus.wb_we  = 1'b0;
    if (!got_ack) check_eq("ack_timeout", 8'h00, 8'h01);
  endtask

  task automatic read_check(input logic [1:0] a, input logic [7:0] exp, input string tag);
    logic [7:0] d;
    bus_access(1'b0, a, 8'h00, d);
    check_eq(tag, d, exp);
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [7:0] wd);
    logic [7:0] d;
    bus_access(1'b1, a, wd, d);
  endtask

  // scoreboard: every queued byte must come out of DATA in order
  task automatic drain_expected(input string tag);
    logic [7:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      read_check(2'd0, e, tag);
    end
  endtask

  initial begin
    logic [7:0] d;
    reset_n        = 1'b0;
    rx_bit         = 1'b1;
    bus.wb_addr    = 2'd0;
    bus.wb_data_in = 8'h00;
    bus.wb_we      = 1'b0;
    bus.wb_stb     = 1'b0;
    wait_cycles(5);
    reset_n = 1'b1;
    wait_cycles(2);

    // reset state
    check_eq("rst_ack", {7'd0, bus.wb_ack}, 8'h00);
    check_eq("rst_data_out", bus.wb_data_out, 8'h00);
    check_eq("rst_irq", {7'd0, rx_irq}, 8'h00);
    check_eq("rst_state", {6'd0, dbg_state}, 8'h00);
    read_check(2'd1, 8'h00, "rst_status");
    read_check(2'd0, 8'h00, "rst_data_empty");

    // single byte
    send_byte(8'h41, 1'b1);
    exp_q.push_back(8'h41);
    read_check(2'd1, 8'h11, "single_status");
    check_eq("single_irq", {7'd0, rx_irq}, 8'h01);
    drain_expected("single_data");
    read_check(2'd1, 8'h00, "single_status_after");
    check_eq("single_irq_after", {7'd0, rx_irq}, 8'h00);
    read_check(2'd2, 8'h00, "addr2_read");
    read_check(2'd3, 8'h00, "addr3_read");

    // overrun: fifth byte dropped
    for (int i = 1; i <= 5; i++) begin
      send_byte(8'(i), 1'b1);
      if (i <= 4) exp_q.push_back(8'(i));
    end
    read_check(2'd1, 8'h47, "ovr_status");
    reg_write(2'd0, 8'hFF);
    read_check(2'd1, 8'h47, "ovr_status_data_write_ignored");
    drain_expected("ovr_data");
    read_check(2'd0, 8'h00, "ovr_data_empty");
    reg_write(2'd1, 8'h04);
    read_check(2'd1, 8'h00, "ovr_clear");

    // framing error
    send_byte(8'hA5, 1'b0);
    wait_cycles(10);
    read_check(2'd1, 8'h08, "frame_status");
    reg_write(2'd1, 8'h08);
    read_check(2'd1, 8'h00, "frame_clear");

    // glitch rejection
    rx_bit = 1'b0;
    wait_cycles(20);
    rx_bit = 1'b1;
    wait_cycles(200);
    read_check(2'd1, 8'h00, "glitch_status");
    send_byte(8'h3C, 1'b1);
    exp_q.push_back(8'h3C);
    read_check(2'd1, 8'h11, "glitch_next_status");
    drain_expected("glitch_next_data");

    // reset during data bit 3
    fork
      send_byte(8'hFF, 1'b1);
      begin
        wait_cycles(CPB * 4 + 40);
        reset_n = 1'b0;
        wait_cycles(3);
        reset_n = 1'b1;
      end
    join
    wait_cycles(10);
    read_check(2'd1, 8'h00, "rst_mid_status");
    send_byte(8'h5A, 1'b1);
    exp_q.push_back(8'h5A);
    read_check(2'd1, 8'h11, "rst_mid_next_status");
    drain_expected("rst_mid_data");

    // simultaneous push and pop while full
    for (int i = 0; i < 4; i++) begin
      send_byte(8'h10 + 8'(i), 1'b1);
      exp_q.push_back(8'h10 + 8'(i));
    end
    read_check(2'd1, 8'h43, "full_status");
    fork
      send_byte(8'h14, 1'b1);
      begin
        // pin low after edge k; edge seen at k+3, stop sample at k+991, push at k+992
        wait_cycles(991);
        bus_access(1'b0, 2'd0, 8'h00, d);
        check_eq("pushpop_data", d, exp_q.pop_front());
      end
    join
    exp_q.push_back(8'h14);
    read_check(2'd1, 8'h43, "pushpop_status");
    drain_expected("pushpop_order");
    read_check(2'd1, 8'h00, "final_status");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
